rob_multiport: RTL and testbench

//  Parametrised reorder buffer: circular, in-order allocate and retire, out-of-order completion.

---
 rtl/rob_multiport.sv | 169 ++++++++++++++++
 tb/tb_rob_multiport.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
`default_nettype none
// ============================================================================
// rob_multiport -- circular reorder buffer: in-order allocate/retire,
// out-of-order completion on NUM_WB channels, mispredict squash with flush.
// Revision: 1.0
// ============================================================================
module rob_multiport #(
  parameter int DEPTH    = 32,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int PREG_W   = 7,
  parameter int NUM_WB   = 4,
  parameter int RETIRE_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic                       alloc_has_dest,
  input  logic [PREG_W-1:0]          alloc_pd_new,
  input  logic [PREG_W-1:0]          alloc_pd_old,
  input  logic [31:0]                alloc_pc,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic                       br_mispredict,
  input  logic [TAG_W-1:0]           br_tag,
  output logic                       flush,
  output logic [TAG_W-1:0]           flush_tag,
  output logic [RETIRE_W-1:0]        retire_valid,
  output logic [RETIRE_W-1:0]        retire_free,
  output logic [RETIRE_W*PREG_W-1:0] retire_pd_old,
  output logic [RETIRE_W*32-1:0]     retire_pc,
  output logic [TAG_W-1:0]           head,
  output logic [TAG_W:0]             count
);

  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0]             r_done;
  logic [DEPTH-1:0]             r_has_dest;
  logic [DEPTH-1:0][PREG_W-1:0] r_pd_new;
  logic [DEPTH-1:0][PREG_W-1:0] r_pd_old;
  logic [DEPTH-1:0][31:0]       r_pc;
  logic [TAG_W-1:0]             r_head;
  logic [TAG_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;
  logic                         r_flush;
  logic [TAG_W-1:0]             r_flush_tag;

  logic                         w_full;
  logic                         w_br_take;
  logic                         w_alloc;
  logic [TAG_W-1:0]             w_br_age;
  logic [DEPTH-1:0]             w_wb_hit;
  logic [DEPTH-1:0]             w_squash;
  logic [DEPTH-1:0]             w_ret_clr;
  logic [CNT_W-1:0]             w_ret_cnt;
  logic                         w_unused_pd_new;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign alloc_ready = !w_full && !r_flush;
  assign w_br_age    = br_tag - r_head;
  assign w_br_take   = br_mispredict && !r_flush && r_valid[br_tag];
  assign w_alloc     = alloc_valid && alloc_ready && !w_br_take;

  // pd_new is kept for rename-side debug; nothing downstream reads it here
  assign w_unused_pd_new = ^r_pd_new;

  assign alloc_tag = r_tail;
  assign head      = r_head;
  assign count     = r_count;
  assign flush     = r_flush;
  assign flush_tag = r_flush_tag;

  always_comb begin
    w_wb_hit = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i]) w_wb_hit[wb_tag[i*TAG_W +: TAG_W]] = 1'b1;
    end
  end

  always_comb begin
    w_squash = '0;
    for (int e = 0; e < DEPTH; e++) begin
      w_squash[e] = w_br_take && ((TAG_W'(e) - r_head) > w_br_age);
    end
  end

  // Retire window: a contiguous run of valid&&done entries starting at head,
  // never reaching past a branch being squashed this cycle.
  always_comb begin : retire_window
    logic             chain;
    logic [TAG_W-1:0] idx;
    chain         = 1'b1;
    idx           = '0;
    retire_valid  = '0;
    retire_free   = '0;
    retire_pd_old = '0;
    retire_pc     = '0;
    w_ret_clr     = '0;
    w_ret_cnt     = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      idx   = r_head + TAG_W'(k);
      chain = chain && r_valid[idx] && r_done[idx] &&
              (!w_br_take || (TAG_W'(k) <= w_br_age));
      if (chain) begin
        retire_valid[k]                    = 1'b1;
        retire_free[k]                     = r_has_dest[idx];
        retire_pd_old[k*PREG_W +: PREG_W]  = r_pd_old[idx];
        retire_pc[k*32 +: 32]              = r_pc[idx];
        w_ret_clr[idx]                     = 1'b1;
        w_ret_cnt                          = w_ret_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_alloc && (r_tail == TAG_W'(e))) begin
          r_valid[e] <= 1'b1;
          r_done[e]  <= 1'b0;
        end else if (w_ret_clr[e] || w_squash[e]) begin
          r_valid[e] <= 1'b0;
          r_done[e]  <= 1'b0;
        end else if (w_wb_hit[e] && r_valid[e]) begin
          r_done[e]  <= 1'b1;
        end
      end
    end
  end

  // Payload fields need no reset: they are only read behind valid.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_has_dest[r_tail] <= alloc_has_dest;
      r_pd_new[r_tail]   <= alloc_pd_new;
      r_pd_old[r_tail]   <= alloc_pd_old;
      r_pc[r_tail]       <= alloc_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_flush     <= 1'b0;
      r_flush_tag <= '0;
    end else begin
      r_head      <= r_head + w_ret_cnt[TAG_W-1:0];
      r_flush     <= w_br_take;
      r_flush_tag <= w_br_take ? br_tag : '0;
      if (w_br_take) begin
        r_tail  <= br_tag + TAG_W'(1);
        r_count <= CNT_W'(w_br_age) + CNT_W'(1) - w_ret_cnt;
      end else begin
        r_tail  <= r_tail + TAG_W'(w_alloc);
        r_count <= r_count + CNT_W'(w_alloc) - w_ret_cnt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// ============================================================================
// tb_rob_multiport -- directed bench for rob_multiport at default parameters.
// Revision: 1.0
// ============================================================================
module tb_rob_multiport;

  logic        clk;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic        alloc_has_dest;
  logic [6:0]  alloc_pd_new;
  logic [6:0]  alloc_pd_old;
  logic [31:0] alloc_pc;
  logic [4:0]  alloc_tag;
  logic [3:0]  wb_valid;
  logic [19:0] wb_tag;
  logic        br_mispredict;
  logic [4:0]  br_tag;
  logic        flush;
  logic [4:0]  flush_tag;
  logic [1:0]  retire_valid;
  logic [1:0]  retire_free;
  logic [13:0] retire_pd_old;
  logic [63:0] retire_pc;
  logic [4:0]  head;
  logic [5:0]  count;

  int total;
  int bad;

  rob_multiport dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_has_dest(alloc_has_dest), .alloc_pd_new(alloc_pd_new),
    .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .br_mispredict(br_mispredict), .br_tag(br_tag),
    .flush(flush), .flush_tag(flush_tag),
    .retire_valid(retire_valid), .retire_free(retire_free),
    .retire_pd_old(retire_pd_old), .retire_pc(retire_pc),
    .head(head), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic [6:0] pdo);
    alloc_valid    = 1'b1;
    alloc_has_dest = 1'b1;
    alloc_pd_old   = pdo;
    alloc_pd_new   = pdo ^ 7'h40;
    alloc_pc       = pc;
    tick();
    alloc_valid    = 1'b0;
  endtask

  initial begin
    logic [4:0] t;
    total = 0; bad = 0;
    reset = 1'b1; alloc_valid = 1'b0; alloc_has_dest = 1'b0;
    alloc_pd_new = '0; alloc_pd_old = '0; alloc_pc = '0;
    wb_valid = '0; wb_tag = '0; br_mispredict = 1'b0; br_tag = '0;
    do_reset();

    // reset state
    chk("rst_count", count, 0);
    chk("rst_head", head, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_flush", flush, 0);
    chk("rst_flush_tag", flush_tag, 0);
    chk("rst_retire", retire_valid, 0);
    chk("rst_pd_old", retire_pd_old, 0);

    // three allocations without completion
    for (int i = 0; i < 3; i++) begin
      chk("alloc_tag", alloc_tag, i);
      do_alloc(32'h100 + 32'(4 * i), 7'(10 + i));
    end
    chk("a3_count", count, 3);
    chk("a3_retire", retire_valid, 0);
    chk("a3_head", head, 0);

    // out-of-order pair completion on two channels
    do_alloc(32'h10c, 7'd13);
    wb_valid = 4'b0011;
    wb_tag   = {5'd0, 5'd0, 5'd0, 5'd1};
    chk("wb_not_yet", retire_valid, 0);
    tick();
    wb_valid = '0;
    chk("pair_retire", retire_valid, 2'b11);
    chk("pair_free", retire_free, 2'b11);
    chk("pair_pd_old", retire_pd_old, {7'd11, 7'd10});
    chk("pair_pc", retire_pc, {32'h104, 32'h100});
    tick();
    chk("pair_head", head, 2);
    chk("pair_count", count, 2);

    // fill to full; 33rd request ignored
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        chk("fill31_count", count, 31);
        chk("fill31_ready", alloc_ready, 1);
      end
      do_alloc(32'h1000 + 32'(4 * i), 7'(i));
    end
    chk("full_count", count, 32);
    chk("full_ready", alloc_ready, 0);
    chk("full_tail", alloc_tag, 0);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("over_count", count, 32);
    chk("over_tail", alloc_tag, 0);

    // drain to head=30, then wrap the retire window across 31->0
    for (int c = 0; c < 8; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        t = 5'(4 * c + ch);
        wb_tag[ch*5 +: 5] = t;
        wb_valid[ch]      = (4 * c + ch) < 30;
      end
      tick();
    end
    wb_valid = '0;
    for (int n = 0; n < 40 && head != 5'd30; n++) tick();
    chk("drain_head", head, 30);
    chk("drain_count", count, 2);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("wrap_alloc_tag", alloc_tag, 3);
      do_alloc(32'h2000 + 32'(4 * i), 7'(40 + i));
    end
    chk("wrap_count", count, 6);
    wb_valid = 4'b0011;
    wb_tag   = {5'd0, 5'd0, 5'd31, 5'd30};
    tick();
    wb_valid = '0;
    chk("wrap_retire", retire_valid, 2'b11);
    chk("wrap_pc", retire_pc, {32'h107c, 32'h1078});
    chk("wrap_pd_old", retire_pd_old, {7'd31, 7'd30});
    tick();
    chk("wrap_head", head, 0);
    chk("wrap_count2", count, 4);

    // mispredict squash with a same-cycle allocation
    do_reset();
    for (int i = 0; i < 10; i++) do_alloc(32'h3000 + 32'(4 * i), 7'(i));
    br_mispredict = 1'b1;
    br_tag        = 5'd4;
    alloc_valid   = 1'b1;
    chk("mp_ready", alloc_ready, 1);
    tick();
    br_mispredict = 1'b0;
    alloc_valid   = 1'b0;
    chk("mp_flush", flush, 1);
    chk("mp_flush_tag", flush_tag, 4);
    chk("mp_count", count, 5);
    chk("mp_tail", alloc_tag, 5);
    chk("mp_ready_flush", alloc_ready, 0);
    // second mispredict during flush and a stale completion are both ignored
    br_mispredict = 1'b1;
    br_tag        = 5'd2;
    wb_valid      = 4'b0001;
    wb_tag        = {5'd0, 5'd0, 5'd0, 5'd7};
    tick();
    br_mispredict = 1'b0;
    wb_valid      = '0;
    chk("mp2_flush", flush, 0);
    chk("mp2_count", count, 5);
    chk("mp2_tail", alloc_tag, 5);
    chk("mp2_retire", retire_valid, 0);
    chk("mp2_ready", alloc_ready, 1);

    // mispredict on an empty slot is ignored
    do_reset();
    br_mispredict = 1'b1;
    br_tag        = 5'd5;
    tick();
    br_mispredict = 1'b0;
    chk("inv_br_flush", flush, 0);

    // retirement alongside a mispredict, then reset in the flush cycle
    for (int i = 0; i < 3; i++) do_alloc(32'h4000 + 32'(4 * i), 7'(20 + i));
    wb_valid = 4'b0001;
    wb_tag   = '0;
    tick();
    wb_valid      = '0;
    br_mispredict = 1'b1;
    br_tag        = 5'd2;
    #1;
    chk("mr_retire", retire_valid, 2'b01);
    tick();
    br_mispredict = 1'b0;
    chk("mr_flush", flush, 1);
    chk("mr_flush_tag", flush_tag, 2);
    chk("mr_count", count, 2);
    chk("mr_head", head, 1);
    chk("mr_tail", alloc_tag, 3);
    tick();
    chk("mr_pulse", flush, 0);
    br_mispredict = 1'b1;
    br_tag        = 5'd2;
    tick();
    br_mispredict = 1'b0;
    chk("mr_flush_again", flush, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rf_flush", flush, 0);
    chk("rf_count", count, 0);
    chk("rf_head", head, 0);
    chk("rf_tail", alloc_tag, 0);
    chk("rf_ready", alloc_ready, 1);
    chk("rf_retire", retire_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
